// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of a pipelined constant-dividend divider,
// returning each result in issue order, tagged with its requester, with flush/drain.
module divider_arbiter #(
  parameter int M = 4,
  parameter int M_ACTIVE_MIN = 2,
  parameter int SERIES = 5,
  parameter int LAT = 5,
  parameter int NREQ = 4,
  parameter int CW = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*M-1:0]         req_divisor,
  output logic [NREQ-1:0]           ack,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [M-1:0]              div_divisor,
  input  logic [SERIES-1:0]         div_merchant,
  input  logic [M-1:0]              div_remainder,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [SERIES-1:0]         rsp_merchant,
  output logic [M-1:0]              rsp_remainder,
  output logic                      rsp_err,
  output logic [CW-1:0]             inflight
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2;
  localparam logic [M-1:0] DMIN = M'(1 << (M_ACTIVE_MIN - 1));
  logic [1:0] state, nxt;
  logic [IW-1:0] ptr, win, j;
  logic found, grant, err;
  logic [M-1:0] sel;
  logic tag_v [LAT+1];
  logic [IW-1:0] tag_id [LAT+1];
  logic tag_err [LAT+1];
  always_comb begin
    win = ptr;
    j = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (j == IW'(NREQ - 1)) ? '0 : j + IW'(1);
      if (!found && req[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  assign grant = rstn && state == RUN && !flush && found;
  assign ack = grant ? NREQ'(1) << win : '0;
  assign sel = req_divisor[win * M +: M];
  assign err = sel < DMIN;
  always_comb
    nxt = state == RUN   ? (flush ? DRAIN : RUN) :
          state == DRAIN ? (!flush ? RUN : inflight == '0 ? DONE : DRAIN) :
                           (flush ? DONE : RUN);
  // the tag tail lines up with the cycle the divider presents that issue's result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RUN;
      ptr <= IW'(NREQ - 1);
      div_divisor <= '0;
      inflight <= '0;
      flush_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_merchant <= '0;
      rsp_remainder <= '0;
      rsp_err <= 1'b0;
      for (int k = 0; k <= LAT; k++) begin
        tag_v[k] <= 1'b0;
        tag_id[k] <= '0;
        tag_err[k] <= 1'b0;
      end
    end else begin
      state <= nxt;
      flush_done <= nxt == DONE;
      if (grant) begin
        ptr <= win;
        div_divisor <= err ? '1 : sel;
      end
      tag_v[0] <= grant;
      tag_id[0] <= win;
      tag_err[0] <= err;
      for (int k = 1; k <= LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
        tag_err[k] <= tag_err[k-1];
      end
      rsp_valid <= tag_v[LAT];
      rsp_id <= tag_v[LAT] ? tag_id[LAT] : '0;
      rsp_err <= tag_v[LAT] && tag_err[LAT];
      rsp_merchant <= tag_v[LAT] && !tag_err[LAT] ? div_merchant : '0;
      rsp_remainder <= tag_v[LAT] && !tag_err[LAT] ? div_remainder : '0;
      inflight <= grant == tag_v[LAT] ? inflight : grant ? inflight + CW'(1) : inflight - CW'(1);
    end
  end
endmodule
